sddac_mc: RTL and testbench

SDDAC_MC -- requirements
Module: sddac_mc

---
 rtl/sddac_mc.sv | 190 +++++++++++++++++++
 tb/tb_sddac_mc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sddac_mc.sv
// -----------------------------------------------------------------------------
// sddac_mc -- multi-channel sigma-delta DAC modulator.
//
// Accepts frames of CHANNELS signed DATA_W-bit samples through a valid/ready
// handshake, double-buffers them (pending -> active) on a sample-period strobe
// produced by a free-running 0..OSR-1 counter, and drives one first- or
// second-order 1-bit modulator per channel from the active frame.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   run control; low idles and clears modulator state
//   sample_in    in   CHANNELS*DATA_W packed samples, channel k at [k*DATA_W +: DATA_W]
//   sample_valid in   sample_in carries a frame
//   sample_ready out  frame is accepted this cycle (combinational)
//   dac_out      out  registered 1-bit modulator output per channel
//   underrun     out  one-cycle pulse: a sample period began with no pending frame
// -----------------------------------------------------------------------------
module sddac_mc #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ORDER    = 2,
  parameter int unsigned OSR      = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [CHANNELS*DATA_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic [CHANNELS-1:0]        dac_out,
  output logic                       underrun
);

  localparam int unsigned FRAME_W = CHANNELS * DATA_W;
  localparam int unsigned CNT_W   = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  // Integrator widths: first stage DATA_W+2, second stage DATA_W+4.
  localparam int unsigned W1 = DATA_W + 2;
  localparam int unsigned W2 = DATA_W + 4;

  // Feedback magnitude 2^(DATA_W-1), carried one bit wider than stage 1.
  localparam logic signed [W1:0] FB1 = (W1 + 1)'(2 ** (DATA_W - 1));

  if ((ORDER != 1) && (ORDER != 2)) begin : g_bad_order
    $error("sddac_mc: ORDER must be 1 or 2");
  end

  if ((CHANNELS < 1) || (CHANNELS > 8) || (DATA_W < 8) || (DATA_W > 24) || (OSR < 4))
  begin : g_bad_geometry
    $error("sddac_mc: CHANNELS/DATA_W/OSR out of range");
  end

  // ---------------------------------------------------------------------------
  // Period counter, handshake and two-stage frame buffer
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_full_q, pend_full_d;
  logic [FRAME_W-1:0] pend_q, pend_d;
  logic [FRAME_W-1:0] act_q, act_d;
  logic               underrun_q, underrun_d;
  logic               strobe;
  logic               accept;

  always_comb begin
    strobe       = enable && (cnt_q == CNT_LAST);
    sample_ready = enable && (!pend_full_q || strobe);
    accept       = sample_valid && sample_ready;

    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    act_d       = act_q;
    underrun_d  = 1'b0;

    if (!enable) begin
      // Idle: period restarts from zero and any pending frame is dropped;
      // the active frame is deliberately kept.
      cnt_d       = '0;
      pend_full_d = 1'b0;
    end else begin
      cnt_d = strobe ? '0 : cnt_q + 1'b1;
      if (strobe) begin
        underrun_d = !pend_full_q;
        if (pend_full_q) begin
          act_d = pend_q;
        end
        // Pending slot was either just emptied or already empty, so it is
        // full afterwards only if a frame arrives on this very edge.
        pend_full_d = accept;
      end else begin
        pend_full_d = pend_full_q || accept;
      end
      if (accept) begin
        pend_d = sample_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      underrun_q  <= underrun_d;
    end
  end

  assign underrun = underrun_q;

  // ---------------------------------------------------------------------------
  // Per-channel modulators (independent; share only act_q and enable)
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic signed [DATA_W-1:0] x;
    logic signed [W1:0]       fb1;
    logic signed [W1:0]       sum1;
    logic signed [W1-1:0]     i1_sat;
    logic signed [W1-1:0]     i1_q, i1_d;
    logic                     out_q, out_d;

    assign x = act_q[k*DATA_W +: DATA_W];

    always_comb begin
      fb1  = out_q ? FB1 : -FB1;
      sum1 = {i1_q[W1-1], i1_q} + {{3{x[DATA_W-1]}}, x} - fb1;
      // One guard bit is enough: if it disagrees with the sign bit the true
      // sum left the W1-bit range, so clamp to the limit on that side.
      if (sum1[W1] != sum1[W1-1]) begin
        i1_sat = sum1[W1] ? {1'b1, {(W1-1){1'b0}}} : {1'b0, {(W1-1){1'b1}}};
      end else begin
        i1_sat = sum1[W1-1:0];
      end
      i1_d = enable ? i1_sat : '0;
    end

    if (ORDER == 2) begin : g_o2
      localparam logic signed [W2:0] FB2 = (W2 + 1)'(2 ** (DATA_W - 1));
      logic signed [W2:0]   fb2;
      logic signed [W2:0]   sum2;
      logic signed [W2-1:0] i2_sat;
      logic signed [W2-1:0] i2_q, i2_d;

      always_comb begin
        fb2  = out_q ? FB2 : -FB2;
        sum2 = {i2_q[W2-1], i2_q} + {{3{i1_sat[W1-1]}}, i1_sat} - fb2;
        if (sum2[W2] != sum2[W2-1]) begin
          i2_sat = sum2[W2] ? {1'b1, {(W2-1){1'b0}}} : {1'b0, {(W2-1){1'b1}}};
        end else begin
          i2_sat = sum2[W2-1:0];
        end
        i2_d  = enable ? i2_sat : '0;
        out_d = enable && !i2_sat[W2-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          i2_q <= '0;
        end else begin
          i2_q <= i2_d;
        end
      end
    end else begin : g_o1
      always_comb begin
        out_d = enable && !i1_sat[W1-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        i1_q  <= '0;
        out_q <= 1'b0;
      end else begin
        i1_q  <= i1_d;
        out_q <= out_d;
      end
    end

    assign dac_out[k] = out_q;
  end

endmodule

// File: tb/tb_sddac_mc.sv
// -----------------------------------------------------------------------------
// tb_sddac_mc -- self-checking bench for sddac_mc.
//
// Two instances (ORDER=1 and ORDER=2, 2 channels, 16-bit, OSR=64) share one
// stimulus stream. A behavioural model (integer arithmetic, a queue for the
// pending frame) predicts dac_out, underrun and sample_ready every cycle;
// directed phases add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sddac_mc;

  localparam int CH  = 2;
  localparam int DW  = 16;
  localparam int OSR = 64;

  typedef logic [CH*DW-1:0] frame_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sample_valid;
  frame_t        sample_in;
  logic          rdy1, rdy2, und1, und2;
  logic [CH-1:0] dac1, dac2;

  sddac_mc #(.CHANNELS(CH), .DATA_W(DW), .ORDER(1), .OSR(OSR)) u_o1 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (rdy1),
    .dac_out      (dac1),
    .underrun     (und1)
  );

  sddac_mc #(.CHANNELS(CH), .DATA_W(DW), .ORDER(2), .OSR(OSR)) u_o2 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (rdy2),
    .dac_out      (dac2),
    .underrun     (und2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: index [o][c], o=0 -> ORDER 1 instance, o=1 -> ORDER 2
  // ---------------------------------------------------------------------------
  int     m_cnt;
  frame_t m_act;
  frame_t m_pend[$];
  longint m_i1[2][CH];
  longint m_i2[2][CH];
  bit     m_out[2][CH];
  bit     m_und;

  function automatic longint clamp(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_step(input logic rst, input logic en, input logic vld, input frame_t din);
    bit     strobe, rdy;
    longint x, fb;
    if (rst || !en) begin
      m_cnt = 0;
      m_und = 0;
      m_pend.delete();
      for (int o = 0; o < 2; o++)
        for (int c = 0; c < CH; c++) begin
          m_i1[o][c]  = 0;
          m_i2[o][c]  = 0;
          m_out[o][c] = 0;
        end
      if (rst) m_act = '0;
    end else begin
      strobe = (m_cnt == OSR - 1);
      rdy    = (m_pend.size() == 0) || strobe;
      for (int o = 0; o < 2; o++)
        for (int c = 0; c < CH; c++) begin
          x  = longint'($signed(m_act[c*DW +: DW]));
          fb = m_out[o][c] ? (longint'(1) <<< (DW - 1)) : -(longint'(1) <<< (DW - 1));
          m_i1[o][c] = clamp(m_i1[o][c] + x - fb, DW + 2);
          if (o == 1) begin
            m_i2[o][c]  = clamp(m_i2[o][c] + m_i1[o][c] - fb, DW + 4);
            m_out[o][c] = (m_i2[o][c] >= 0);
          end else begin
            m_out[o][c] = (m_i1[o][c] >= 0);
          end
        end
      m_und = strobe && (m_pend.size() == 0);
      if (strobe && (m_pend.size() != 0)) m_act = m_pend.pop_front();
      if (vld && rdy) m_pend.push_back(din);
      m_cnt = strobe ? 0 : m_cnt + 1;
    end
  endtask

  // Compare process: model advances on each edge, DUT checked 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      model_step(reset, enable, sample_valid, sample_in);
      #1;
      chk("dac_o1", dac1, {m_out[0][1], m_out[0][0]});
      chk("dac_o2", dac2, {m_out[1][1], m_out[1][0]});
      chk("underrun_o1", und1, m_und);
      chk("underrun_o2", und2, m_und);
      chk("ready_o1", rdy1, enable && ((m_pend.size() == 0) || (m_cnt == OSR - 1)));
      chk("ready_o2", rdy2, enable && ((m_pend.size() == 0) || (m_cnt == OSR - 1)));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  int          ones1[CH];
  int          ones2[CH];
  int          und_cnt;
  int          acc;
  int          first_und;
  bit          found;
  logic [15:0] w0, w1;
  logic [3:0]  rec[2][150];

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_dac_o1", dac1, 0);
    chk("reset_dac_o2", dac2, 0);
    chk("reset_underrun", und2, 0);
    chk("reset_ready", rdy2, 0);

    // Zero frame, 4096 cycles: balanced bitstream, underrun every period after the first
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; sample_valid = 1'b1; sample_in = '0;
    und_cnt = 0;
    for (int c = 0; c < CH; c++) begin ones1[c] = 0; ones2[c] = 0; end
    for (int n = 1; n <= 4096; n++) begin
      @(posedge clk); #1;
      for (int c = 0; c < CH; c++) begin
        ones1[c] += int'(dac1[c]);
        ones2[c] += int'(dac2[c]);
      end
      if (und2) und_cnt++;
      if (n == 1) begin
        @(negedge clk);
        sample_valid = 1'b0;
      end
    end
    chk("zero_ones_o2_ch0", ones2[0], 2049);
    chk("zero_ones_o2_ch1", ones2[1], 2049);
    chk("zero_ones_o1_ch0", ones1[0], 2049);
    chk("zero_ones_o2_band", (ones2[0] >= 2044) && (ones2[0] <= 2052), 1);
    chk("zero_underruns", und_cnt, 63);

    // sample_valid held high: one accept at release, then one per strobe
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; sample_valid = 1'b1;
    acc = 0; und_cnt = 0;
    for (int n = 0; n < 192; n++) begin
      w0 = 16'(n * 13 + 4096);
      w1 = 16'(n * 7 + 40960);
      sample_in = {w1, w0};
      #1;
      if (rdy2) acc++;
      @(posedge clk); #1;
      if (und2) und_cnt++;
      @(negedge clk);
    end
    chk("stream_accepts", acc, 4);
    chk("stream_underruns", und_cnt, 0);

    // Full-scale frames on ORDER 1: ch0 0x7FFF, ch1 0x8000
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; sample_valid = 1'b1; sample_in = {16'h8000, 16'h7FFF};
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (63) @(posedge clk);
    for (int c = 0; c < CH; c++) ones1[c] = 0;
    for (int n = 0; n < 1024; n++) begin
      @(posedge clk); #1;
      for (int c = 0; c < CH; c++) ones1[c] += int'(dac1[c]);
    end
    chk("fullscale_pos_bound", ones1[0] >= 1022, 1);
    chk("fullscale_neg_bound", ones1[1] <= 2, 1);
    chk("fullscale_pos_ones", ones1[0], 1023);
    chk("fullscale_neg_ones", ones1[1], 0);

    // Frame arriving on the strobe cycle with pending empty
    found = 1'b0;
    for (int n = 0; (n < 130) && !found; n++) begin
      @(posedge clk); #1;
      if (und2) found = 1'b1;
    end
    chk("underrun_seen", found, 1);
    repeat (63) @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b1; sample_in = {16'hE000, 16'h1234};
    @(posedge clk); #1;
    chk("late_frame_underrun", und2, 1);
    chk("late_frame_pending", rdy2, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (63) @(posedge clk);
    @(posedge clk); #1;
    chk("late_frame_moved_und", und2, 0);
    chk("late_frame_moved_rdy", rdy2, 1);

    // Reset mid-period with a pending frame
    @(negedge clk);
    sample_valid = 1'b1; sample_in = {16'h4000, 16'hC000};
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("pending_before_reset", rdy2, 0);
    reset = 1'b1;
    #1;
    chk("async_reset_dac_o1", dac1, 0);
    chk("async_reset_dac_o2", dac2, 0);
    chk("async_reset_underrun", und2, 0);
    @(negedge clk);
    reset = 1'b0;
    und_cnt = 0; first_und = 0;
    for (int n = 1; n <= 130; n++) begin
      @(posedge clk); #1;
      if (und2) begin
        und_cnt++;
        if (first_und == 0) first_und = n;
      end
    end
    chk("first_strobe_after_reset", first_und, 64);
    chk("pending_discarded", und_cnt, 2);

    // enable dropped for 10 cycles, twice: restart bitstreams must match
    @(negedge clk);
    sample_valid = 1'b1; sample_in = {16'hD000, 16'h3000};
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (100) @(posedge clk);
    for (int ep = 0; ep < 2; ep++) begin
      @(negedge clk);
      enable = 1'b0;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        chk("idle_dac_o1", dac1, 0);
        chk("idle_dac_o2", dac2, 0);
        chk("idle_ready", rdy2, 0);
      end
      @(negedge clk);
      enable = 1'b1;
      for (int n = 0; n < 150; n++) begin
        @(posedge clk); #1;
        rec[ep][n] = {dac1, dac2};
      end
    end
    for (int n = 0; n < 150; n++) chk("restart_bitstream", rec[1][n], rec[0][n]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
